// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester RAM port arbiter.
package mem_arb_pkg;

  // Arbiter FSM: free arbitration or a locked owner
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;

  // Requester id: 0 or 1
  typedef logic req_id_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input picker: a lone valid requester wins; on a tie the requester
// that is not last_gnt wins, unless fixed_prio forces requester 0.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_gnt,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);

  // One-hot grant selection
  always_comb begin
    gnt = 2'b00;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (fixed_prio || last_gnt) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares RAM port A between two requesters: round-robin per beat, locked
// bursts bounded by MAX_BURST, 1-cycle read response routing.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: IDLE ties always go to
// requester 0 (release after a full burst still alternates).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam logic IDLE_FIXED = 1'b1;
`else
  localparam logic IDLE_FIXED = 1'b0;
`endif

  arb_state_t       state_reg, state_next;
  req_id_t          last_gnt_reg, last_gnt_next;
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic             rsp_pend_reg;
  req_id_t          rsp_id_reg;

  logic [1:0] valid_vec, lock_vec, we_vec;
  logic [1:0] idle_gnt, rel_gnt, pick, gnt, accept;
  logic       use_pick;
  req_id_t    owner;

  assign valid_vec = {req1_valid, req0_valid};
  assign lock_vec  = {req1_lock, req0_lock};
  assign we_vec    = {req1_we, req0_we};
  assign owner     = (state_reg == OWN1);

  // Free arbitration honours the optional fixed priority
  rr_pick2 u_idle_pick (
    .valid      (valid_vec),
    .last_gnt   (last_gnt_reg),
    .fixed_prio (IDLE_FIXED),
    .gnt        (idle_gnt)
  );

  // Release arbitration treats the outgoing owner as last granted, so a
  // waiting contender always gets the next beat after a full burst
  rr_pick2 u_rel_pick (
    .valid      (valid_vec),
    .last_gnt   (owner),
    .fixed_prio (1'b0),
    .gnt        (rel_gnt)
  );

  // State register plus read-response tag; async reset drops everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
      beat_cnt_reg <= '0;
      rsp_pend_reg <= 1'b0;
      rsp_id_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      beat_cnt_reg <= beat_cnt_next;
      rsp_pend_reg <= |(accept & ~we_vec);
      rsp_id_reg   <= accept[1];
    end
  end

  // Next-state and grant: owner keeps the port while allowed, else arbitrate
  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    beat_cnt_next = beat_cnt_reg;
    gnt           = 2'b00;
    pick          = 2'b00;
    use_pick      = 1'b0;
    case (state_reg)
      OWN0, OWN1: begin
        if (valid_vec[owner] && (!valid_vec[~owner] || beat_cnt_reg < CNT_MAX)) begin
          gnt[owner]    = 1'b1;
          last_gnt_next = owner;
          if (beat_cnt_reg != CNT_MAX) beat_cnt_next = beat_cnt_reg + CNT_ONE;
          if (!lock_vec[owner]) begin
            state_next    = IDLE;
            beat_cnt_next = '0;
          end
        end else begin
          use_pick = 1'b1;
          pick     = rel_gnt;
        end
      end
      default: begin
        use_pick = 1'b1;
        pick     = idle_gnt;
      end
    endcase
    if (use_pick) begin
      gnt           = pick;
      state_next    = IDLE;
      beat_cnt_next = '0;
      if (pick != 2'b00) begin
        last_gnt_next = pick[1];
        if (lock_vec[pick[1]]) begin
          state_next    = pick[1] ? OWN1 : OWN0;
          beat_cnt_next = CNT_ONE;
        end
      end
    end
  end

  // Outputs: gated ready, winner's memory drive, tagged read response
  always_comb begin
    accept     = gnt & {2{reset}};
    req0_ready = accept[0];
    req1_ready = accept[1];
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    if (accept[0]) begin
      mem_we   = req0_we;
      mem_addr = req0_addr;
      mem_data = req0_wdata;
    end else if (accept[1]) begin
      mem_we   = req1_we;
      mem_addr = req1_addr;
      mem_data = req1_wdata;
    end
    rsp0_valid = rsp_pend_reg && !rsp_id_reg;
    rsp1_valid = rsp_pend_reg && rsp_id_reg;
    rsp0_rdata = rsp0_valid ? mem_q : '0;
    rsp1_rdata = rsp1_valid ? mem_q : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus a reset sequence.
// Build macro MEM_ARB_FIXED_PRIO_EN selects the fixed-priority expectations.
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid, req0_we, req0_lock, req0_ready, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_we, req1_lock, req1_ready, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_we;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
  );

  // RAM model: preset pattern A500^addr, write then registered read
  logic [DW-1:0] ram [0:1023];
  bit            ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 16'hA500 ^ 16'(i);
      ram_ready <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_data;
      mem_q <= ram[mem_addr];
    end
  end

  typedef struct {
    logic          v0, we0, lk0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1, we1, lk1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [1:0]    e_gnt;   // {req1_ready, req0_ready}
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [1:0]    e_rspv;  // {rsp1_valid, rsp0_valid}
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int v0, we0, lk0, a0, d0, v1, we1, lk1, a1, d1,
                              input int g, ewe, ea, ed, rv, rd);
    vec_t r;
    r.v0 = v0[0]; r.we0 = we0[0]; r.lk0 = lk0[0]; r.a0 = AW'(a0); r.d0 = DW'(d0);
    r.v1 = v1[0]; r.we1 = we1[0]; r.lk1 = lk1[0]; r.a1 = AW'(a1); r.d1 = DW'(d1);
    r.e_gnt = 2'(g); r.e_we = ewe[0]; r.e_addr = AW'(ea); r.e_data = DW'(ed);
    r.e_rspv = 2'(rv); r.e_rdata = DW'(rd);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_we = v.we0; req0_lock = v.lk0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_we = v.we1; req1_lock = v.lk1; req1_addr = v.a1; req1_wdata = v.d1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ready"}, {req1_ready, req0_ready}, 2'b00);
    chk({nm, "_mem"}, {mem_we, mem_addr, mem_data}, '0);
    chk({nm, "_rspv"}, {rsp1_valid, rsp0_valid}, 2'b00);
    chk({nm, "_rdata"}, {rsp1_rdata, rsp0_rdata}, '0);
  endtask

  initial begin
    // single requester: write BEEF@005, read it back
    vecs.push_back(mk(1,1,0,'h005,'hBEEF, 0,0,0,0,0,       'b01,1,'h005,'hBEEF, 'b00,0));
    vecs.push_back(mk(1,0,0,'h005,0,      0,0,0,0,0,       'b01,0,'h005,0,      'b00,0));
    vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,0,       'b00,0,0,0,          'b01,'hBEEF));
`ifdef MEM_ARB_FIXED_PRIO_EN
    // contention without lock: requester 0 wins every tie
    vecs.push_back(mk(1,0,0,'h010,0, 1,0,0,'h020,0, 'b01,0,'h010,0, 'b00,0));
    vecs.push_back(mk(1,0,0,'h011,0, 1,0,0,'h020,0, 'b01,0,'h011,0, 'b01,'hA510));
    vecs.push_back(mk(1,0,0,'h012,0, 1,0,0,'h020,0, 'b01,0,'h012,0, 'b01,'hA511));
    vecs.push_back(mk(1,0,0,'h013,0, 1,0,0,'h020,0, 'b01,0,'h013,0, 'b01,'hA512));
    vecs.push_back(mk(0,0,0,0,0,     1,0,0,'h020,0, 'b10,0,'h020,0, 'b01,'hA513));
    vecs.push_back(mk(0,0,0,0,0,     0,0,0,0,0,     'b00,0,0,0,     'b10,'hA520));
`else
    // contention without lock: grants alternate 1,0,1,0 (last_gnt was 0)
    vecs.push_back(mk(1,0,0,'h010,0, 1,0,0,'h020,0, 'b10,0,'h020,0, 'b00,0));
    vecs.push_back(mk(1,0,0,'h010,0, 1,0,0,'h021,0, 'b01,0,'h010,0, 'b10,'hA520));
    vecs.push_back(mk(1,0,0,'h011,0, 1,0,0,'h021,0, 'b10,0,'h021,0, 'b01,'hA510));
    vecs.push_back(mk(1,0,0,'h011,0, 1,0,0,'h022,0, 'b01,0,'h011,0, 'b10,'hA521));
    vecs.push_back(mk(0,0,0,0,0,     1,0,0,'h022,0, 'b10,0,'h022,0, 'b01,'hA511));
    vecs.push_back(mk(0,0,0,0,0,     0,0,0,0,0,     'b00,0,0,0,     'b10,'hA522));
`endif
    // locked burst of 6 reads by req0 vs continuous req1: 0,0,0,0,1,0,0
    vecs.push_back(mk(1,0,1,'h040,0, 1,0,0,'h050,0, 'b01,0,'h040,0, 'b00,0));
    vecs.push_back(mk(1,0,1,'h041,0, 1,0,0,'h050,0, 'b01,0,'h041,0, 'b01,'hA540));
    vecs.push_back(mk(1,0,1,'h042,0, 1,0,0,'h050,0, 'b01,0,'h042,0, 'b01,'hA541));
    vecs.push_back(mk(1,0,1,'h043,0, 1,0,0,'h050,0, 'b01,0,'h043,0, 'b01,'hA542));
    vecs.push_back(mk(1,0,1,'h044,0, 1,0,0,'h050,0, 'b10,0,'h050,0, 'b01,'hA543));
    vecs.push_back(mk(1,0,1,'h044,0, 1,0,0,'h051,0, 'b01,0,'h044,0, 'b10,'hA550));
    vecs.push_back(mk(1,0,0,'h045,0, 1,0,0,'h051,0, 'b01,0,'h045,0, 'b01,'hA544));
    vecs.push_back(mk(0,0,0,0,0,     1,0,0,'h051,0, 'b10,0,'h051,0, 'b01,'hA545));
    vecs.push_back(mk(0,0,0,0,0,     0,0,0,0,0,     'b00,0,0,0,     'b10,'hA551));
    // req1 locks, writes, then drops valid: req0 granted in that same cycle
    vecs.push_back(mk(0,0,0,0,0,     1,0,1,'h060,0,       'b10,0,'h060,0,       'b00,0));
    vecs.push_back(mk(1,0,0,'h070,0, 1,1,1,'h061,'h1234, 'b10,1,'h061,'h1234, 'b10,'hA560));
    vecs.push_back(mk(1,0,0,'h070,0, 0,0,0,0,0,           'b01,0,'h070,0,       'b00,0));
    // read-after-write of 061
    vecs.push_back(mk(0,0,0,0,0,     1,0,0,'h061,0,       'b10,0,'h061,0,       'b01,'hA570));
    vecs.push_back(mk(0,0,0,0,0,     0,0,0,0,0,           'b00,0,0,0,           'b10,'h1234));

    // reset state, with requests pending so ready gating is exercised
    drive(mk(1,1,1,'h3FF,'hFFFF, 1,0,1,'h155,'hAAAA, 0,0,0,0,0,0));
    #2;
    chk_quiet("reset_state");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      $display("vec %0d: r0 v=%b a=%h r1 v=%b a=%h -> ready=%b%b we=%b addr=%h data=%h rsp=%b%b",
               i, vecs[i].v0, vecs[i].a0, vecs[i].v1, vecs[i].a1, req1_ready, req0_ready,
               mem_we, mem_addr, mem_data, rsp1_valid, rsp0_valid);
      chk($sformatf("v%0d_ready", i), {req1_ready, req0_ready}, vecs[i].e_gnt);
      chk($sformatf("v%0d_mem", i), {mem_we, mem_addr, mem_data},
          {vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data});
      chk($sformatf("v%0d_rspv", i), {rsp1_valid, rsp0_valid}, vecs[i].e_rspv);
      chk($sformatf("v%0d_rdata", i), {rsp1_rdata, rsp0_rdata},
          {vecs[i].e_rspv[1] ? vecs[i].e_rdata : 16'h0, vecs[i].e_rspv[0] ? vecs[i].e_rdata : 16'h0});
      @(posedge clk);
      #1;
    end

    // reset mid-burst with a read accepted in the reset cycle
    drive(mk(1,0,1,'h080,0, 0,0,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    $display("seq burst start: ready=%b%b", req1_ready, req0_ready);
    chk("rst_burst_start", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk);
    #1 drive(mk(1,0,1,'h081,0, 1,0,0,'h090,0, 0,0,0,0,0,0));
    #1;
    $display("seq burst beat2: ready=%b%b rsp0=%b data=%h", req1_ready, req0_ready, rsp0_valid, rsp0_rdata);
    chk("rst_beat2_ready", {req1_ready, req0_ready}, 2'b01);
    chk("rst_beat2_rsp", {rsp0_valid, rsp0_rdata}, {1'b1, 16'hA580});
    #1 reset = 1'b0;
    #1;
    $display("seq reset asserted: ready=%b%b we=%b rsp=%b%b", req1_ready, req0_ready, mem_we, rsp1_valid, rsp0_valid);
    chk_quiet("rst_async");
    @(posedge clk);
    #1 chk_quiet("rst_held");
    @(posedge clk);
    #1 reset = 1'b1;
    drive(mk(1,0,0,'h0A0,0, 1,0,0,'h0B0,0, 0,0,0,0,0,0));
    @(negedge clk);
    $display("seq after reset tie: ready=%b%b addr=%h rsp=%b%b", req1_ready, req0_ready, mem_addr, rsp1_valid, rsp0_valid);
    chk("rst_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("rst_first_tie", {req1_ready, req0_ready}, 2'b01);
    chk("rst_tie_addr", {mem_we, mem_addr}, {1'b0, 10'h0A0});
    @(posedge clk);
    #1 drive(mk(0,0,0,0,0, 1,0,0,'h0B0,0, 0,0,0,0,0,0));
    @(negedge clk);
    $display("seq after reset r1: ready=%b%b rsp0=%b data=%h", req1_ready, req0_ready, rsp0_valid, rsp0_rdata);
    chk("rst_r1_ready", {req1_ready, req0_ready}, 2'b10);
    chk("rst_r0_rsp", {rsp1_valid, rsp0_valid, rsp0_rdata}, {2'b01, 16'hA5A0});
    @(posedge clk);
    #1 drive(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    $display("seq final: rsp1=%b data=%h", rsp1_valid, rsp1_rdata);
    chk("rst_r1_rsp", {rsp1_valid, rsp0_valid, rsp1_rdata}, {2'b10, 16'hA5B0});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares port A of the `DualPortMemory` (single-cycle synchronous RAM) between two masters, for example the `memory_FSM` tester and a display or readback engine. It grants one access per cycle using round-robin, supports locked bursts with a bounded length, and drives the RAM address, data and write-enable. It returns read data to the winning requester with a fixed 1-cycle latency.

## Interface
Parameters:
- `DATA_W`, 16, RAM word width
- `ADDR_W`, 10, RAM address width
- `MAX_BURST`, 4, maximum consecutive beats one locked owner may take while the other requester waits; legal range is 1 or more

Ports (`x` = 0, 1):
- `clk`  in  1  sole clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `reqx_valid`  in  1  requester x has an access pending
- `reqx_we`  in  1  1 = write, 0 = read
- `reqx_lock`  in  1  request to keep ownership after this beat
- `reqx_addr`  in  `ADDR_W`  access address
- `reqx_wdata`  in  `DATA_W`  write data
- `reqx_ready`  out  1  beat accepted this cycle (combinational)
- `rspx_valid`  out  1  read data for requester x is valid this cycle
- `rspx_rdata`  out  `DATA_W`  read data; equals `mem_q` whenever `rspx_valid` is high, otherwise 0
- `mem_addr`  out  `ADDR_W`  to RAM `addr_a`
- `mem_data`  out  `DATA_W`  to RAM `data_a`
- `mem_we`  out  1  to RAM `we_a`
- `mem_q`  in  `DATA_W`  from RAM `q_a`; valid the cycle after the address is presented

## Operation
- A beat transfers when `reqx_valid && reqx_ready`. At most one `reqx_ready` is high per cycle, and `reqx_ready` never rises without `reqx_valid`.
- Requesters hold `valid`, `we`, `lock`, `addr` and `wdata` stable until accepted.
- State machine states: IDLE, OWN0, OWN1. The block also holds:
  - `last_gnt`: 1 bit, the most recently accepted requester
  - `beat_cnt`: counts accepted beats in the current ownership
- **IDLE arbitration:**
  - One requester valid: it wins.
  - Both valid: the requester that is not `last_gnt` wins.
  - Winner's `lock=1`: go to OWNwinner with `beat_cnt=1`. Otherwise stay in IDLE.
  - `last_gnt` updates on every accepted beat.
- **OWNx exclusive grant:** x is granted exclusively if `reqx_valid` is high and either the other requester is idle or `beat_cnt < MAX_BURST`.
  - Each accepted beat increments `beat_cnt`.
  - An accepted beat with `lock=0` returns the FSM to IDLE.
- **Release in OWNx:** if x drops `valid`, or `beat_cnt == MAX_BURST` while the other requester is valid:
  - the same cycle is arbitrated exactly as IDLE, with `last_gnt` = x;
  - the next state follows the IDLE rules.
- **Memory drive:**
  - On an accepted beat: `mem_addr`/`mem_data`/`mem_we` = winner's `addr`/`wdata`/`we`.
  - With no accepted beat: `mem_we=0`, `mem_addr=0`, `mem_data=0`.
- **Read response:** an accepted read registers a 1-bit pending tag with the requester id. The next cycle, `rspx_valid=1` for the tagged requester only. Accepted writes produce no response.
- **Read-after-write:** a write in cycle N followed by a read of the same address in N+1 returns the new data. This is guaranteed by the RAM's write-then-read across cycles.
- **Reset values:** on reset assertion, regardless of clock:
  - state IDLE, `last_gnt=1` (so requester 0 wins the first tie), `beat_cnt=0`, pending tag cleared;
  - all `ready`, `rsp_valid`, `mem_we` = 0;
  - `mem_addr=0`, `mem_data=0`, `rspx_rdata=0`.
  - A read accepted in the cycle reset asserts gets no response.

## Timing
- Acceptance is combinational in the request cycle N. The RAM samples address, data and write-enable at the end of N.
- Read latency is exactly 1: `rspx_valid` is high in N+1.
- Throughput is 1 beat per cycle, back-to-back, including alternating requesters.
- Under continuous contention without lock, grants alternate 0,1,0,1.
- With a continuous lock, the owner takes `MAX_BURST` consecutive beats, then the other requester gets one beat.
- The `beat_cnt` width is enough to hold `MAX_BURST`. `beat_cnt` saturates at `MAX_BURST` while no contender is present.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`:
  - **Defined:** IDLE ties always go to requester 0, and `last_gnt` is ignored for arbitration. Burst limiting still applies, so requester 1 is guaranteed one beat after each `MAX_BURST` locked run.
  - **Undefined:** round-robin, as described under Operation.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE, OWN0, OWN1);
  - the default `DATA_W`/`ADDR_W` constants;
  - the 1-bit requester-id type.
- One sub-module, `rr_pick2`: a combinational two-input picker with inputs `valid[1:0]`, `last_gnt` and a fixed-priority select, and a one-hot grant output. It is reused by the IDLE path and the release path.

## Test plan
- **Reset:** assert `reset=0` mid-burst with a read accepted -> all outputs 0 immediately; no `rsp_valid` after release; first tie goes to requester 0.
- **Single requester:** req0 writes 0xBEEF @ 0x005, then reads 0x005 -> `mem_we=1` in cycle N, `rsp0_valid=1` with 0xBEEF in N+2, `rsp1_valid` stays 0.
- **Round-robin:** both requesters read continuously, no lock -> grants alternate 0,1,0,1, with each `rspx_valid` one cycle after that requester's grant.
- **Locked burst:** req0 locks 6 reads, req1 valid throughout, `MAX_BURST=4` -> grants 0,0,0,0,1,0,0 and the FSM returns to IDLE after the final `lock=0` beat.
- **Lock release:** in OWN1, req1 drops `valid` while req0 is valid -> req0 is granted that same cycle.
- **Fixed priority:** with `MEM_ARB_FIXED_PRIO_EN` defined and both requesters continuously valid without lock -> requester 0 wins every cycle.
